// File: rtl/led_seq_if.sv
// LED sequencer port bundle: pattern select in, LED drive and step pulse out.
// Latency: none, wires only.
// Backpressure: none; the outputs run freely.
interface led_seq_if #(
    parameter int N_LED = 2
);
    logic [1:0]       mode;
    logic [N_LED-1:0] led;
    logic             step_tick;

    modport master (
        output mode,
        input  led,
        input  step_tick
    );

    modport slave (
        input  mode,
        output led,
        output step_tick
    );
endinterface

// File: rtl/led_seq.sv
// Multi-channel status LED sequencer (off / walk / blink / breathe) on active-low pins; breathe needs LED_SEQ_BREATHE_EN.
// Latency: led and step_tick registered; a mode change reaches led 2 cycles after the input moves.
// Backpressure: none; the outputs are free-running and cannot be stalled.
module led_seq #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int STEP_MS  = 500,
    parameter int N_LED    = 2,
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    led_seq_if.slave bus
);
    localparam int STEP_CYC = CLK_HZ / 1000 * STEP_MS;
    localparam int PRESC_W  = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int POS_W    = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYC - 1);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(N_LED - 1);

    if (STEP_CYC < 2 || N_LED < 1 || N_LED > 16 || PWM_BITS < 2 || PWM_BITS > 10 || RAMP_DIV < 1) begin : g_param_check
        $error("led_seq: parameter out of range");
    end

    logic [1:0]         mode_q;
    logic               restart_q;
    logic [PRESC_W-1:0] presc;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   pos_eff;
    logic               phase;
    logic               tick_q;
    logic [N_LED-1:0]   led_q;
    logic [N_LED-1:0]   led_nxt;
    logic               change;
    logic               step;
    logic               breathe_lit;

    // A pending mode change or an ongoing restart swallows the step boundary.
    assign change  = (bus.mode != mode_q);
    assign step    = (presc == PRESC_LAST) && !change && !restart_q;
    assign pos_eff = restart_q ? '0 : pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 2'd0;
            restart_q <= 1'b0;
            presc     <= '0;
            pos       <= '0;
            phase     <= 1'b0;
            tick_q    <= 1'b0;
            led_q     <= '1;
        end else begin
            mode_q    <= bus.mode;
            restart_q <= change;
            tick_q    <= step;
            led_q     <= led_nxt;
            if (restart_q) begin
                presc <= '0;
                pos   <= '0;
                phase <= 1'b0;
            end else begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                if (step) begin
                    pos   <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                    phase <= ~phase;
                end
            end
        end
    end

`ifdef LED_SEQ_BREATHE_EN
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0]   RAMP_LAST     = RAMP_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST      = '1;
    localparam logic [PWM_BITS-1:0] DUTY_NEAR_TOP = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] DUTY_ONE      = PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic                dir_down;

    // Direction flips on the step that lands on an endpoint, so each endpoint lasts one ramp step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            duty     <= '0;
            ramp_cnt <= '0;
            dir_down <= 1'b0;
        end else if (restart_q) begin
            pwm_cnt  <= '0;
            duty     <= '0;
            ramp_cnt <= '0;
            dir_down <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == PWM_LAST) begin
                if (ramp_cnt == RAMP_LAST) begin
                    ramp_cnt <= '0;
                    if (!dir_down) begin
                        duty <= duty + 1'b1;
                        if (duty == DUTY_NEAR_TOP) begin
                            dir_down <= 1'b1;
                        end
                    end else begin
                        duty <= duty - 1'b1;
                        if (duty == DUTY_ONE) begin
                            dir_down <= 1'b0;
                        end
                    end
                end else begin
                    ramp_cnt <= ramp_cnt + 1'b1;
                end
            end
        end
    end

    assign breathe_lit = !restart_q && (pwm_cnt < duty);
`else
    assign breathe_lit = 1'b0;
`endif

    always_comb begin
        led_nxt = '1;
        case (mode_q)
            2'd1: begin
                for (int i = 0; i < N_LED; i++) begin
                    led_nxt[i] = (pos_eff != POS_W'(i));
                end
            end
            2'd2:    led_nxt = (phase && !restart_q) ? '1 : '0;
            2'd3:    led_nxt = breathe_lit ? '0 : '1;
            default: led_nxt = '1;
        endcase
    end

    assign bus.led       = led_q;
    assign bus.step_tick = tick_q;
endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq: STEP_CYC = 10, four LEDs, 3-bit PWM, ramp every 2 PWM periods.
module tb_led_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_seq_if #(.N_LED(4)) bus ();

    led_seq #(
        .CLK_HZ  (1000),
        .STEP_MS (10),
        .N_LED   (4),
        .PWM_BITS(3),
        .RAMP_DIV(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.mode = 2'd0;
        rst_n    = 1'b0;
        repeat (3) cyc();
        checks++;
        if (bus.led !== 4'b1111) begin
            errors++;
            $display("FAIL reset_led: got %b expected 1111", bus.led);
        end
        checks++;
        if (bus.step_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b expected 0", bus.step_tick);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_off();
        logic exp_tick;
        for (int c = 1; c <= 50; c++) begin
            cyc();
            exp_tick = (c % 10 == 0);
            checks++;
            if (bus.led !== 4'b1111) begin
                errors++;
                $display("FAIL off_led c=%0d: got %b expected 1111", c, bus.led);
            end
            checks++;
            if (bus.step_tick !== exp_tick) begin
                errors++;
                $display("FAIL off_tick c=%0d: got %b expected %b", c, bus.step_tick, exp_tick);
            end
        end
    endtask

    task automatic test_walk();
        logic [3:0] one;
        logic [3:0] exp_led;
        logic       exp_tick;
        int         pos;
        one = 4'b0001;
        bus.mode = 2'd1;
        for (int r = 1; r <= 55; r++) begin
            cyc();
            pos      = ((r - 1 >= 12) ? ((r - 13) / 10 + 1) : 0) % 4;
            exp_led  = (r < 2) ? 4'b1111 : (4'b1111 ^ (one << pos));
            exp_tick = (r >= 12) && ((r - 12) % 10 == 0);
            checks++;
            if (bus.led !== exp_led) begin
                errors++;
                $display("FAIL walk_led r=%0d: got %b expected %b", r, bus.led, exp_led);
            end
            checks++;
            if (bus.step_tick !== exp_tick) begin
                errors++;
                $display("FAIL walk_tick r=%0d: got %b expected %b", r, bus.step_tick, exp_tick);
            end
        end
    endtask

    // Mode 1 -> 2 lands on the cycle the prescaler reads 9, then the blink pattern runs.
    task automatic test_blink_boundary();
        bit         found;
        logic [3:0] exp_led;
        logic       exp_tick;
        int         ph;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (bus.step_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sync_tick: no step_tick within 20 cycles, got none expected one");
        end
        repeat (9) cyc();
        bus.mode = 2'd2;
        for (int e = 1; e <= 45; e++) begin
            cyc();
            ph       = ((e - 1 >= 12) ? ((e - 13) / 10 + 1) : 0) % 2;
            exp_led  = (ph == 1) ? 4'b1111 : 4'b0000;
            exp_tick = (e >= 12) && ((e - 12) % 10 == 0);
            if (e >= 2) begin
                checks++;
                if (bus.led !== exp_led) begin
                    errors++;
                    $display("FAIL blink_led e=%0d: got %b expected %b", e, bus.led, exp_led);
                end
            end
            checks++;
            if (bus.step_tick !== exp_tick) begin
                errors++;
                $display("FAIL blink_tick e=%0d: got %b expected %b", e, bus.step_tick, exp_tick);
            end
        end
    endtask

    task automatic test_breathe();
        logic exp_tick;
        int   r;
        bus.mode = 2'd3;
        cyc();
        cyc();
        r = 2;
        checks++;
        if (bus.led !== 4'b1111) begin
            errors++;
            $display("FAIL breathe_entry_led: got %b expected 1111", bus.led);
        end
`ifdef LED_SEQ_BREATHE_EN
        begin
            int on;
            int k;
            int exp_on;
            int bad;
            bad = 0;
            for (int w = 0; w < 30; w++) begin
                on = 0;
                for (int j = 0; j < 8; j++) begin
                    cyc();
                    r++;
                    if (bus.led === 4'b0000) on++;
                    else if (bus.led !== 4'b1111) bad++;
                    exp_tick = (r >= 12) && ((r - 12) % 10 == 0);
                    checks++;
                    if (bus.step_tick !== exp_tick) begin
                        errors++;
                        $display("FAIL breathe_tick r=%0d: got %b expected %b", r, bus.step_tick, exp_tick);
                    end
                end
                k      = w / 2;
                exp_on = (k <= 7) ? k : (14 - k);
                checks++;
                if (on !== exp_on) begin
                    errors++;
                    $display("FAIL breathe_duty w=%0d: got on-count %0d expected %0d", w, on, exp_on);
                end
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL breathe_uniform: got %0d mixed samples expected 0", bad);
            end
        end
`else
        for (int i = 0; i < 38; i++) begin
            cyc();
            r++;
            exp_tick = (r >= 12) && ((r - 12) % 10 == 0);
            checks++;
            if (bus.led !== 4'b1111) begin
                errors++;
                $display("FAIL mode3_dark r=%0d: got %b expected 1111", r, bus.led);
            end
            checks++;
            if (bus.step_tick !== exp_tick) begin
                errors++;
                $display("FAIL mode3_tick r=%0d: got %b expected %b", r, bus.step_tick, exp_tick);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_walk();
        bus.mode = 2'd1;
        repeat (25) cyc();
        checks++;
        if (bus.led !== 4'b1011) begin
            errors++;
            $display("FAIL midwalk_pos2: got %b expected 1011", bus.led);
        end
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.led !== 4'b1111) begin
            errors++;
            $display("FAIL async_reset_led: got %b expected 1111", bus.led);
        end
        checks++;
        if (bus.step_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_tick: got %b expected 0", bus.step_tick);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (bus.led !== 4'b1111) begin
            errors++;
            $display("FAIL rewalk_c1: got %b expected 1111", bus.led);
        end
        cyc();
        checks++;
        if (bus.led !== 4'b1110) begin
            errors++;
            $display("FAIL rewalk_c2: got %b expected 1110", bus.led);
        end
    endtask

    initial begin
        test_reset();
        test_off();
        test_walk();
        test_blink_boundary();
        test_breathe();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_seq.md
# led_seq

Parametrised multi-channel LED sequencer for the Control Board status LEDs. One prescaler, shared by all channels, sets the step rate. A runtime mode input selects one of four patterns: all-off, walking one, blink-all and breathe (PWM). The block sits at board top level and drives the active-low LED pins directly.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `STEP_MS`, 500, step period in ms. `STEP_CYC = CLK_HZ/1000*STEP_MS` must be ≥ 2. The prescaler width is `$clog2(STEP_CYC)`.
- `N_LED`, 2, number of LED channels, 1..16.
- `PWM_BITS`, 8, PWM resolution for breathe mode, 2..10.
- `RAMP_DIV`, 4, number of PWM periods per duty increment in breathe mode, ≥ 1.
---
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mode` in 2: 0 = off, 1 = walk, 2 = blink, 3 = breathe.
- `led` out `N_LED`: LED drive, active-low (1 = dark). Registered.
- `step_tick` out 1: one-cycle pulse at every step boundary. Registered.

## Operation
- `mode` is registered into `mode_q` every cycle.
  - When `mode != mode_q`, a restart occurs in the next cycle: prescaler = 0, `pos` = 0, `phase` = 0, `duty` = 0, `dir` = up, `pwm_cnt` = 0, `ramp_cnt` = 0.
  - A restart suppresses `step_tick` in that cycle.
- Prescaler: counts 0..`STEP_CYC-1`, then wraps to 0. `step_tick` asserts in the cycle after the count equals `STEP_CYC-1`. The prescaler runs in all modes.
- Mode 0, off: `led` = all 1.
- Mode 1, walk:
  - `pos` ranges 0..`N_LED-1` and advances on each step boundary, wrapping from `N_LED-1` to 0.
  - `led[i]` = 0 only when i == `pos`.
  - With `N_LED` = 1, the single LED stays lit.
- Mode 2, blink:
  - `phase` toggles on each step boundary.
  - `phase` = 0 → all lit (`led` = 0). `phase` = 1 → all dark.
  - First step after entry: lit.
- Mode 3, breathe:
  - `pwm_cnt` is a free-running `PWM_BITS`-bit counter.
  - All channels are lit while `pwm_cnt < duty`. `duty` = 0 → always dark.
  - On each `pwm_cnt` wrap, `ramp_cnt` increments. When `ramp_cnt` reaches `RAMP_DIV-1` it resets to 0 and `duty` steps by ±1.
  - Direction reverses when `duty` reaches `2^PWM_BITS-1` (direction becomes down) or 0 (direction becomes up).
  - No overflow or underflow: the endpoint is held for exactly one ramp step before reversing.
  - Breathe ignores the step prescaler except for `step_tick`.
- Unused mode encodings: none, since all four are defined. When breathe is compiled out, mode 3 is handled as described in Configuration.

## Timing
- Reset values: `led` = all 1, `step_tick` = 0, `mode_q` = 0, all counters 0, `dir` = up.
- Output latency: `led` updates one clock after the internal state changes, because it is a registered output.
- After `rst_n` deasserts with `mode` held at 1, `led[0]` is lit from cycle 2 onward.
- First `step_tick` appears `STEP_CYC` cycles after reset release or restart. After that it repeats every `STEP_CYC` cycles.
- A mode change lands on the LEDs 2 cycles after the `mode` input changes (`mode_q` register, then restart, then the `led` register).
- Simultaneous mode change and step boundary: the restart wins and the step is discarded.
- Asserting `rst_n` mid-pattern forces `led` to all 1 asynchronously. The pattern restarts from state 0 after release.

## Configuration
- `LED_SEQ_BREATHE_EN` defined: breathe mode, the PWM counter, the ramp counter and the duty logic are built.
- Not defined: none of that breathe logic exists. Mode 3 behaves exactly as mode 0 (all dark), and `step_tick` still runs.

## Test plan
Unless stated otherwise, the bench uses `CLK_HZ` = 1000, `STEP_MS` = 10 (`STEP_CYC` = 10), `N_LED` = 4, `PWM_BITS` = 3, `RAMP_DIV` = 2.
- Reset, then `mode` = 0 for 50 cycles → `led` = 4'b1111 throughout; `step_tick` pulses every 10 cycles.
- `mode` = 1 → `led` sequence 1110, 1101, 1011, 0111, 1110, with transitions 1 cycle after each `step_tick`; wrap is checked.
- `mode` = 2 → `led` alternates 0000 and 1111 every 10 cycles, starting with 0000.
- `mode` = 3 with the macro defined → duty reaches 7 then returns to 0. The on-count per 8-cycle PWM window is checked against `duty` on every window. Without the macro → `led` = 1111.
- Change `mode` 1 → 2 in the same cycle the prescaler hits 9 → no `step_tick` is emitted, and `led` = 0000 exactly 2 cycles after the change.
- Assert `rst_n` mid-walk at `pos` = 2 → `led` = 1111 immediately. After release with `mode` = 1 → `led` = 1110.
